// File: rtl/fetch_if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID packet register.
package fetch_if_stage_pkg;

    typedef enum logic [1:0] {
        S_VEC = 2'd0,
        S_OP  = 2'd1,
        S_IMM = 2'd2
    } fetch_state_t;

    localparam logic [1:0] REDIR_NONE = 2'b00;
    localparam logic [1:0] REDIR_RST  = 2'b01;
    localparam logic [1:0] REDIR_JMP  = 2'b10;
    localparam logic [1:0] REDIR_INT  = 2'b11;

    localparam logic [3:0] TWO_BYTE_OPC_DEF = 4'hC;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] pc_reg;
        logic [7:0] pc_plus_1;
        logic       is_2_byte;
        logic       nothing_here;
    } if_pkt_t;

    localparam if_pkt_t PKT_BUBBLE = '{
        instr:        8'h00,
        imm:          8'h00,
        pc_reg:       8'h00,
        pc_plus_1:    8'h00,
        is_2_byte:    1'b0,
        nothing_here: 1'b1
    };

endpackage

// File: rtl/fetch_if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls in, instruction memory port, decode-stage packet out.
interface fetch_if_stage_if;

    logic       stall_D;
    logic       flush_D;
    logic [1:0] redir_sel;
    logic [7:0] redir_target;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] instr_D;
    logic [7:0] imm_D;
    logic [7:0] pc_reg_D;
    logic [7:0] pc_plus_1_D;
    logic       is_2_byte_D;
    logic       nothing_here_D;

    modport master (
        output stall_D, flush_D, redir_sel, redir_target, imem_rdata,
        input  imem_addr, instr_D, imm_D, pc_reg_D, pc_plus_1_D, is_2_byte_D, nothing_here_D
    );

    modport slave (
        input  stall_D, flush_D, redir_sel, redir_target, imem_rdata,
        output imem_addr, instr_D, imm_D, pc_reg_D, pc_plus_1_D, is_2_byte_D, nothing_here_D
    );

endinterface

// File: rtl/fetch_if_stage_pkt_reg.sv
// IF/ID packet register: bubble-load beats hold, reset loads a bubble.
module fetch_if_stage_pkt_reg
    import fetch_if_stage_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_hold,
    input  logic    i_bubble,
    input  if_pkt_t i_pkt,
    output if_pkt_t o_pkt
);

    if_pkt_t r_pkt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pkt <= PKT_BUBBLE;
        end else if (i_bubble) begin
            r_pkt <= PKT_BUBBLE;
        end else if (!i_hold) begin
            r_pkt <= i_pkt;
        end
    end

    assign o_pkt = r_pkt;

endmodule

// File: rtl/fetch_if_stage.sv
// Instruction fetch: PC/vector FSM, two-byte instruction assembly, IF/ID packet register.
module fetch_if_stage
    import fetch_if_stage_pkg::*;
#(
    parameter logic [3:0] TWO_BYTE_OPC = TWO_BYTE_OPC_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fetch_if_stage_if.slave    bus
);

    fetch_state_t r_state, w_state_nxt;
    logic [7:0]   r_pc, w_pc_nxt;
    logic         r_vec_addr, w_vec_addr_nxt;
    logic [7:0]   r_op_hold, w_op_hold_nxt;
    logic [7:0]   r_op_pc, w_op_pc_nxt;
    logic [7:0]   w_pc_inc;
    logic         w_redir;
    logic         w_bubble;
    if_pkt_t      w_pkt;
    if_pkt_t      w_pkt_q;

    assign w_pc_inc      = r_pc + 8'd1;
    assign w_redir       = (bus.redir_sel != REDIR_NONE);
    assign w_bubble      = w_redir | bus.flush_D;
    assign bus.imem_addr = (r_state == S_VEC) ? {7'd0, r_vec_addr} : r_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_VEC;
            r_pc       <= 8'h00;
            r_vec_addr <= 1'b0;
            r_op_hold  <= 8'h00;
            r_op_pc    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_vec_addr <= w_vec_addr_nxt;
            r_op_hold  <= w_op_hold_nxt;
            r_op_pc    <= w_op_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_vec_addr_nxt = r_vec_addr;
        w_op_hold_nxt  = r_op_hold;
        w_op_pc_nxt    = r_op_pc;
        w_pkt          = PKT_BUBBLE;
        if (w_redir) begin
            // Leaving S_IMM here is what drops a half-fetched opcode.
            case (bus.redir_sel)
                REDIR_JMP: begin
                    w_pc_nxt    = bus.redir_target;
                    w_state_nxt = S_OP;
                end
                REDIR_INT: begin
                    w_vec_addr_nxt = 1'b1;
                    w_state_nxt    = S_VEC;
                end
                default: begin
                    w_vec_addr_nxt = 1'b0;
                    w_state_nxt    = S_VEC;
                end
            endcase
        end else if (!bus.stall_D || bus.flush_D) begin
            case (r_state)
                S_VEC: begin
                    w_pc_nxt    = bus.imem_rdata;
                    w_state_nxt = S_OP;
                end
                S_OP: begin
                    w_pc_nxt = w_pc_inc;
                    if (bus.imem_rdata[7:4] == TWO_BYTE_OPC) begin
                        w_op_hold_nxt = bus.imem_rdata;
                        w_op_pc_nxt   = r_pc;
                        w_state_nxt   = S_IMM;
                    end else begin
                        w_pkt.instr        = bus.imem_rdata;
                        w_pkt.pc_reg       = r_pc;
                        w_pkt.pc_plus_1    = w_pc_inc;
                        w_pkt.nothing_here = 1'b0;
                    end
                end
                S_IMM: begin
                    w_pkt.instr        = r_op_hold;
                    w_pkt.imm          = bus.imem_rdata;
                    w_pkt.pc_reg       = r_op_pc;
                    w_pkt.pc_plus_1    = w_pc_inc;
                    w_pkt.is_2_byte    = 1'b1;
                    w_pkt.nothing_here = 1'b0;
                    w_pc_nxt           = w_pc_inc;
                    w_state_nxt        = S_OP;
                end
                default: w_state_nxt = S_VEC;
            endcase
        end
    end

    fetch_if_stage_pkt_reg u_pkt_reg (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_hold   (bus.stall_D),
        .i_bubble (w_bubble),
        .i_pkt    (w_pkt),
        .o_pkt    (w_pkt_q)
    );

    assign bus.instr_D        = w_pkt_q.instr;
    assign bus.imm_D          = w_pkt_q.imm;
    assign bus.pc_reg_D       = w_pkt_q.pc_reg;
    assign bus.pc_plus_1_D    = w_pkt_q.pc_plus_1;
    assign bus.is_2_byte_D    = w_pkt_q.is_2_byte;
    assign bus.nothing_here_D = w_pkt_q.nothing_here;

endmodule

// File: tb/tb_fetch_if_stage.sv
// Bench for fetch_if_stage: directed scenarios plus randomized controls against a fetch-level model.
module tb_fetch_if_stage;

    logic       clk;
    logic       reset;
    logic [7:0] mem [256];
    int         n_tests;
    int         n_fail;

    fetch_if_stage_if bus ();

    fetch_if_stage dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: where the next fetch comes from, any opcode awaiting its immediate, and the current packet.
    bit         m_valid;
    bit         m_need_vec;
    bit         m_vec;
    bit         m_have_op;
    logic [7:0] m_pc, m_op, m_op_pc;
    logic [7:0] e_instr, e_imm, e_pcr, e_pp1;
    bit         e_is2, e_nh;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] addr, rd;
        bit         n_need_vec, n_vec, n_have_op;
        logic [7:0] n_pc, n_op, n_op_pc;
        logic [7:0] p_instr, p_imm, p_pcr, p_pp1;
        bit         p_is2, p_nh;
        @(negedge clk);
        addr = m_need_vec ? {7'd0, m_vec} : m_pc;
        if (m_valid) begin
            check_val("imem_addr", bus.imem_addr, addr);
            check_val("instr_D", bus.instr_D, e_instr);
            check_val("imm_D", bus.imm_D, e_imm);
            check_val("pc_reg_D", bus.pc_reg_D, e_pcr);
            check_val("pc_plus_1_D", bus.pc_plus_1_D, e_pp1);
            check_val("is_2_byte_D", bus.is_2_byte_D, e_is2);
            check_val("nothing_here_D", bus.nothing_here_D, e_nh);
        end
        rd = mem[addr];
        n_need_vec = m_need_vec; n_vec = m_vec; n_have_op = m_have_op;
        n_pc = m_pc; n_op = m_op; n_op_pc = m_op_pc;
        p_instr = 0; p_imm = 0; p_pcr = 0; p_pp1 = 0; p_is2 = 0; p_nh = 1;
        if (!reset && bus.redir_sel == 2'b00 && (bus.flush_D || !bus.stall_D)) begin
            if (m_need_vec) begin
                n_pc = rd; n_need_vec = 0;
            end else if (m_have_op) begin
                p_instr = m_op; p_imm = rd; p_pcr = m_op_pc; p_pp1 = m_pc + 8'd1;
                p_is2 = 1; p_nh = 0;
                n_pc = m_pc + 8'd1; n_have_op = 0;
            end else if (rd[7:4] == 4'hC) begin
                n_op = rd; n_op_pc = m_pc; n_have_op = 1; n_pc = m_pc + 8'd1;
            end else begin
                p_instr = rd; p_pcr = m_pc; p_pp1 = m_pc + 8'd1; p_nh = 0;
                n_pc = m_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1; m_need_vec = 1; m_vec = 0; m_have_op = 0; m_pc = 0;
            e_instr = 0; e_imm = 0; e_pcr = 0; e_pp1 = 0; e_is2 = 0; e_nh = 1;
        end else if (bus.redir_sel != 2'b00) begin
            m_have_op = 0;
            m_need_vec = (bus.redir_sel != 2'b10);
            m_vec = (bus.redir_sel == 2'b11) ? 1'b1 : (bus.redir_sel == 2'b01) ? 1'b0 : m_vec;
            if (bus.redir_sel == 2'b10) m_pc = bus.redir_target;
            e_instr = 0; e_imm = 0; e_pcr = 0; e_pp1 = 0; e_is2 = 0; e_nh = 1;
        end else if (bus.flush_D || !bus.stall_D) begin
            m_need_vec = n_need_vec; m_vec = n_vec; m_have_op = n_have_op;
            m_pc = n_pc; m_op = n_op; m_op_pc = n_op_pc;
            if (bus.flush_D) begin
                e_instr = 0; e_imm = 0; e_pcr = 0; e_pp1 = 0; e_is2 = 0; e_nh = 1;
            end else begin
                e_instr = p_instr; e_imm = p_imm; e_pcr = p_pcr; e_pp1 = p_pp1;
                e_is2 = p_is2; e_nh = p_nh;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; m_valid = 0;
        m_need_vec = 1; m_vec = 0; m_have_op = 0; m_pc = 0; m_op = 0; m_op_pc = 0;
        e_instr = 0; e_imm = 0; e_pcr = 0; e_pp1 = 0; e_is2 = 0; e_nh = 1;
        reset = 1'b0;
        bus.stall_D = 0; bus.flush_D = 0; bus.redir_sel = 2'b00; bus.redir_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'h21;

        // One-byte instruction after reset
        do_reset();
        check_val("rst_addr", bus.imem_addr, 8'h00);
        check_val("rst_bubble", bus.nothing_here_D, 1'b1);
        check_val("rst_instr", bus.instr_D, 8'h00);
        tick();
        check_val("vec_addr", bus.imem_addr, 8'h10);
        tick();
        check_val("one_instr", bus.instr_D, 8'h21);
        check_val("one_pcr", bus.pc_reg_D, 8'h10);
        check_val("one_pp1", bus.pc_plus_1_D, 8'h11);
        check_val("one_nh", bus.nothing_here_D, 1'b0);

        // Two-byte instruction
        mem[8'h10] = 8'hC4; mem[8'h11] = 8'h5A;
        do_reset(); tick(); tick();
        check_val("two_bubble", bus.nothing_here_D, 1'b1);
        tick();
        check_val("two_instr", bus.instr_D, 8'hC4);
        check_val("two_imm", bus.imm_D, 8'h5A);
        check_val("two_pcr", bus.pc_reg_D, 8'h10);
        check_val("two_pp1", bus.pc_plus_1_D, 8'h12);
        check_val("two_is2", bus.is_2_byte_D, 1'b1);

        // Stall during S_IMM
        do_reset(); tick(); tick();
        bus.stall_D = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_addr", bus.imem_addr, 8'h11);
            check_val("stall_nh", bus.nothing_here_D, 1'b1);
        end
        bus.stall_D = 0;
        tick();
        check_val("stall_done_instr", bus.instr_D, 8'hC4);
        check_val("stall_done_imm", bus.imm_D, 8'h5A);

        // Jump redirect during S_IMM drops the opcode
        mem[8'h40] = 8'h21;
        do_reset(); tick(); tick();
        bus.redir_sel = 2'b10; bus.redir_target = 8'h40;
        tick();
        check_val("jmp_bubble", bus.nothing_here_D, 1'b1);
        check_val("jmp_addr", bus.imem_addr, 8'h40);
        bus.redir_sel = 2'b00;
        tick();
        check_val("jmp_pcr", bus.pc_reg_D, 8'h40);
        check_val("jmp_instr", bus.instr_D, 8'h21);

        // Interrupt vector
        mem[8'h01] = 8'h80; mem[8'h80] = 8'h22;
        bus.redir_sel = 2'b11;
        tick();
        check_val("int_addr", bus.imem_addr, 8'h01);
        bus.redir_sel = 2'b00;
        tick();
        check_val("int_target", bus.imem_addr, 8'h80);
        tick();
        check_val("int_pcr", bus.pc_reg_D, 8'h80);

        // Two-byte opcode at 0xFF wraps
        mem[8'hFF] = 8'hC7; mem[8'h00] = 8'h33;
        bus.redir_sel = 2'b10; bus.redir_target = 8'hFF;
        tick();
        bus.redir_sel = 2'b00;
        tick(); tick();
        check_val("wrap_instr", bus.instr_D, 8'hC7);
        check_val("wrap_imm", bus.imm_D, 8'h33);
        check_val("wrap_pcr", bus.pc_reg_D, 8'hFF);
        check_val("wrap_pp1", bus.pc_plus_1_D, 8'h01);

        // Randomized controls over a random program image
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v[7:4] = 4'hC;
            else if (v[7:4] == 4'hC) v[7:4] = 4'h1;
            mem[i] = v;
        end
        for (int c = 0; c < 4000; c++) begin
            int r;
            reset = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 99);
            bus.redir_sel = (r < 3) ? 2'b10 : (r < 5) ? 2'b01 : (r < 7) ? 2'b11 : 2'b00;
            bus.redir_target = 8'($urandom);
            bus.flush_D = ($urandom_range(0, 9) == 0);
            bus.stall_D = ($urandom_range(0, 6) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_if_stage.md
# fetch_if_stage

Instruction-fetch stage plus IF/ID pipeline register for the 8-bit pipelined processor. It owns the PC, drives the byte-wide instruction memory and assembles two-byte instructions (opcode followed by an immediate byte) into one decode-stage packet. It handles reset and interrupt vector loads from M[0]/M[1], stall and flush from the hazard unit, and PC redirects from execute. Its registered outputs feed the decode stage, which in turn feeds the ID/EX register.

## Interface
Parameters:
- TWO_BYTE_OPC, 4'hC: value of instr[7:4] that marks a two-byte instruction.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high; sampled on the rising edge of clk.
- stall_D, in, 1: hazard unit; hold PC, FSM and outputs.
- flush_D, in, 1: hazard unit; replace the current output with a bubble.
- redir_sel, in, 2: 00 none, 01 reload reset vector M[0], 10 jump to redir_target, 11 interrupt vector M[1].
- redir_target, in, 8: branch, call or return target from execute.
- imem_addr, out, 8: combinational instruction-memory address.
- imem_rdata, in, 8: instruction-memory data, valid in the same cycle as imem_addr.
- instr_D, out, 8: opcode byte.
- imm_D, out, 8: immediate byte; 0 for one-byte instructions.
- pc_reg_D, out, 8: address of the opcode byte.
- pc_plus_1_D, out, 8: address of the next sequential instruction.
- is_2_byte_D, out, 1: packet carries a valid imm_D.
- nothing_here_D, out, 1: 1 means the packet is a bubble (no instruction).

## Operation
- FSM states: S_VEC (PC loads from memory), S_OP (fetch opcode), S_IMM (fetch immediate).
- Reset: PC=0, vec_addr=0, state=S_VEC. Output state is a bubble: all data outputs 0, is_2_byte_D=0, nothing_here_D=1.
- S_VEC:
  - imem_addr=vec_addr.
  - PC<=imem_rdata; state<=S_OP; emit bubble.
- S_OP:
  - imem_addr=PC.
  - If the opcode is one-byte: emit {instr=rdata, imm=0, pc_reg=PC, pc_plus_1=PC+1, is_2_byte=0, nothing_here=0}; PC<=PC+1.
  - If rdata[7:4]==TWO_BYTE_OPC: op_hold<=rdata, op_pc<=PC, PC<=PC+1, state<=S_IMM, emit bubble.
- S_IMM:
  - imem_addr=PC.
  - Emit {instr=op_hold, imm=rdata, pc_reg=op_pc, pc_plus_1=PC+1, is_2_byte=1, nothing_here=0}; PC<=PC+1; state<=S_OP.
- Priority, highest first: reset > redir_sel≠00 > flush_D > stall_D > normal.
  - Redirect in any state: emit bubble and abandon any held opcode.
    - 10: PC<=redir_target, state<=S_OP.
    - 01: vec_addr<=0, state<=S_VEC.
    - 11: vec_addr<=1, state<=S_VEC.
  - flush_D without redirect: emit bubble, PC and FSM advance normally. A partially fetched two-byte instruction continues into S_IMM.
  - stall_D: PC, FSM, op_hold and all outputs hold their values. imem_addr stays stable.
- Arithmetic: PC+1 is modulo 256. A two-byte opcode at 0xFF takes its immediate from 0x00, and pc_plus_1_D=0x01.

## Timing
- One-byte instruction: opcode addressed in cycle n appears on the outputs after edge n+1.
- Two-byte instruction: outputs appear after edge n+2, with a bubble after edge n+1.
- Reset or vector entry: the first instruction appears after the 2nd edge following the S_VEC entry edge (S_VEC cycle, then S_OP cycle).
- All outputs are registered. Only imem_addr is combinational, from state, PC and vec_addr.
- Reset asserted mid-S_IMM: the held opcode is discarded and the next state is S_VEC with vec_addr=0.

## Structure
- Shared package holds:
  - state encoding (S_VEC, S_OP, S_IMM).
  - redir_sel codes (REDIR_NONE/RST/JMP/INT).
  - TWO_BYTE_OPC default.
  - bubble constant (all zero with nothing_here=1).
- Natural sub-module: if_id_pkt_reg, the output packet register with hold, bubble-load and reset. The FSM and PC stay in the top level.

## Test plan
- Reset, M[0]=0x10, M[0x10]=0x21 (one-byte): imem_addr 0x00 then 0x10; 2nd edge after reset release gives instr_D=0x21, pc_reg_D=0x10, pc_plus_1_D=0x11, nothing_here_D=0.
- M[0x10]=0xC4, M[0x11]=0x5A: bubble, then instr_D=0xC4, imm_D=0x5A, pc_reg_D=0x10, pc_plus_1_D=0x12, is_2_byte_D=1.
- stall_D held 3 cycles during S_IMM: outputs, imem_addr and PC frozen; packet completes normally once the stall releases.
- redir_sel=10, redir_target=0x40 during S_IMM: bubble emitted, the 0xC4 opcode is dropped, next packet has pc_reg_D=0x40.
- redir_sel=11 with M[1]=0x80: imem_addr=0x01 for one cycle, then 0x80; first packet pc_reg_D=0x80.
- Two-byte opcode at 0xFF with M[0x00]=0x33: imm_D=0x33, pc_plus_1_D=0x01.
